// File: rtl/view_select_fsm.sv
// rtl/view_select_fsm.sv - debounced push-button view selector with optional auto-cycle (VIEW_AUTOCYCLE_EN)
module view_select_fsm #(
  parameter int NUM_VIEWS       = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int RESET_VIEW      = 0,
  parameter int DWELL_CYCLES    = 1024,
  localparam int VIEW_W         = (NUM_VIEWS > 2) ? $clog2(NUM_VIEWS) : 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_VIEWS-1:0] buttons,
`ifdef VIEW_AUTOCYCLE_EN
  input  logic                 auto_en,
`endif
  output logic [VIEW_W-1:0]    view,
  output logic [NUM_VIEWS-1:0] view_onehot,
  output logic                 view_changed
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [VIEW_W:0]   NUM_VIEWS_X = (VIEW_W + 1)'(NUM_VIEWS);
  localparam logic [VIEW_W-1:0] RESET_V     = VIEW_W'(RESET_VIEW);
  localparam logic [VIEW_W-1:0] LAST_V      = VIEW_W'(NUM_VIEWS - 1);

  // Reject parameter values the logic below cannot honour.
  if (NUM_VIEWS < 2 || NUM_VIEWS > 16 || DEBOUNCE_CYCLES < 1 ||
      RESET_VIEW < 0 || RESET_VIEW >= NUM_VIEWS || DWELL_CYCLES < 2) begin : g_param_check
    $error("view_select_fsm: parameter out of range");
  end

  typedef enum logic {
    ARMED,
    LOCKED
  } state_t;

  state_t               state, state_next;
  logic [NUM_VIEWS-1:0] s1, s2;
  logic [NUM_VIEWS-1:0] db, db_d;
  logic [CNT_W-1:0]     cnt [NUM_VIEWS];
  logic [NUM_VIEWS-1:0] press;
  logic [VIEW_W-1:0]    pick;
  logic [VIEW_W-1:0]    view_next;
  logic [NUM_VIEWS-1:0] onehot_next;
  logic                 changed_next;

`ifdef VIEW_AUTOCYCLE_EN
  localparam int DWELL_W = $clog2(DWELL_CYCLES);
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_CYCLES - 1);
  logic [DWELL_W-1:0] dwell, dwell_next;
`endif

  // Two-flop synchroniser, per-button debounce counter and one-clock delayed debounced level.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1   <= '0;
      s2   <= '0;
      db   <= '0;
      db_d <= '0;
      for (int i = 0; i < NUM_VIEWS; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      s1   <= buttons;
      s2   <= s1;
      db_d <= db;
      for (int i = 0; i < NUM_VIEWS; i++) begin
        if (s2[i] != db[i]) begin
          if (cnt[i] == CNT_LAST) begin
            db[i]  <= s2[i];
            cnt[i] <= '0;
          end else begin
            cnt[i] <= cnt[i] + 1'b1;
          end
        end else begin
          cnt[i] <= '0;
        end
      end
    end
  end

  assign press = db & ~db_d;

  // Lowest-index press wins when several debounce in the same cycle.
  always_comb begin
    pick = '0;
    for (int i = NUM_VIEWS - 1; i >= 0; i--) begin
      if (press[i]) begin
        pick = VIEW_W'(i);
      end
    end
  end

  // Next-state, next-view and change-strobe decode.
  always_comb begin
    state_next   = state;
    view_next    = view;
    changed_next = 1'b0;
`ifdef VIEW_AUTOCYCLE_EN
    dwell_next   = '0;
`endif
    case (state)
      ARMED: begin
        if (|press) begin
          if (pick != view) begin
            view_next    = pick;
            changed_next = 1'b1;
          end
          state_next = LOCKED;
        end
`ifdef VIEW_AUTOCYCLE_EN
        else if (auto_en) begin
          if (dwell == DWELL_LAST) begin
            view_next    = (view == LAST_V) ? '0 : view + 1'b1;
            changed_next = 1'b1;
          end else begin
            dwell_next = dwell + 1'b1;
          end
        end
`endif
      end
      LOCKED: begin
        if (db == '0) begin
          state_next = ARMED;
        end
      end
      default: begin
        state_next = ARMED;
      end
    endcase
    // An out-of-range index can only come from a corrupted register; pull it back home.
    if ({1'b0, view} >= NUM_VIEWS_X) begin
      view_next    = RESET_V;
      changed_next = 1'b1;
    end
    onehot_next = NUM_VIEWS'(1) << view_next;
  end

  // View, its one-hot decode and the change strobe all update from the same registered edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= ARMED;
      view         <= RESET_V;
      view_onehot  <= NUM_VIEWS'(1) << RESET_V;
      view_changed <= 1'b0;
`ifdef VIEW_AUTOCYCLE_EN
      dwell        <= '0;
`endif
    end else begin
      state        <= state_next;
      view         <= view_next;
      view_onehot  <= onehot_next;
      view_changed <= changed_next;
`ifdef VIEW_AUTOCYCLE_EN
      dwell        <= dwell_next;
`endif
    end
  end

endmodule
